// File: rtl/bin_frame_buffer_if.sv
// Bundles the FFT magnitude stream, the display read port and the buffer status outputs.
interface bin_frame_buffer_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DROP_W = 8
);
    logic              mag_valid;
    logic [ADDR_W-1:0] mag_index;
    logic [DATA_W-1:0] mag_data;
    logic              mag_last;
    logic              vsync;
    logic [ADDR_W-1:0] vaddr;
    logic [DATA_W-1:0] vdata;
    logic              front_bank;
    logic              frame_valid;
    logic              swap;
    logic [DROP_W-1:0] frame_drops;

    modport master (
        output mag_valid, mag_index, mag_data, mag_last, vsync, vaddr,
        input  vdata, front_bank, frame_valid, swap, frame_drops
    );

    modport slave (
        input  mag_valid, mag_index, mag_data, mag_last, vsync, vaddr,
        output vdata, front_bank, frame_valid, swap, frame_drops
    );
endinterface

// File: rtl/bin_frame_buffer.sv
// Double-buffered bin magnitude store; FFT fills the back bank, display reads the front bank with 1-cycle latency.
// No backpressure: samples arriving while a complete frame awaits vsync are dropped and counted.
module bin_frame_buffer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    bin_frame_buffer_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {FILL, HOLD, SKIP} state_t;

    state_t            state;
    logic              vsync_d;
    logic              skip_mid;
    logic              front_bank;
    logic              frame_valid;
    logic              swap;
    logic [DROP_W-1:0] frame_drops;

    logic              vsync_edge;
    logic              sample_last;
    logic              swap_now;
    logic              wr_en;
    logic              drop_inc;
    logic              rd_bank;

    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
    logic [DATA_W-1:0] q0;
    logic [DATA_W-1:0] q1;
    logic              rd_sel;
    logic              rd_ok;

    assign vsync_edge  = bus.vsync & ~vsync_d;
    assign sample_last = bus.mag_valid & bus.mag_last;
    assign swap_now    = (state == HOLD) & vsync_edge;
    assign wr_en       = (state == FILL) & bus.mag_valid;
    assign drop_inc    = (state != FILL) & sample_last;
    // The read issued on the swap cycle already sees the incoming front bank.
    assign rd_bank     = swap_now ? ~front_bank : front_bank;

    // Bank storage kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en && front_bank) begin
            mem0[bus.mag_index] <= bus.mag_data;
        end
        if (wr_en && !front_bank) begin
            mem1[bus.mag_index] <= bus.mag_data;
        end
        q0 <= mem0[bus.vaddr];
        q1 <= mem1[bus.vaddr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_sel <= 1'b0;
            rd_ok  <= 1'b0;
        end else begin
            rd_sel <= rd_bank;
            rd_ok  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            vsync_d     <= 1'b0;
            skip_mid    <= 1'b0;
            front_bank  <= 1'b0;
            frame_valid <= 1'b0;
            swap        <= 1'b0;
            frame_drops <= '0;
        end else begin
            vsync_d <= bus.vsync;
            swap    <= swap_now;
            if (drop_inc && (frame_drops != {DROP_W{1'b1}})) begin
                frame_drops <= frame_drops + 1'b1;
            end
            case (state)
                FILL: begin
                    if (sample_last) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    // A discarded last closes the lost frame; a mid sample means one is in flight.
                    if (bus.mag_valid) begin
                        skip_mid <= ~bus.mag_last;
                    end
                    if (vsync_edge) begin
                        front_bank  <= ~front_bank;
                        frame_valid <= 1'b1;
                        skip_mid    <= 1'b0;
                        state       <= (skip_mid && !sample_last) ? SKIP : FILL;
                    end
                end
                SKIP: begin
                    if (sample_last) begin
                        state <= FILL;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.vdata       = rd_ok ? (rd_sel ? q1 : q0) : '0;
    assign bus.front_bank  = front_bank;
    assign bus.frame_valid = frame_valid;
    assign bus.swap        = swap;
    assign bus.frame_drops = frame_drops;
endmodule

// File: tb/tb_bin_frame_buffer.sv
// Directed bench for bin_frame_buffer: swap timing, drops, skip, simultaneous events, saturation, async reset.
module tb_bin_frame_buffer;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;
    localparam int DROP_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    bin_frame_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_W(DROP_W)) bus();

    bin_frame_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_W(DROP_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.mag_valid = 1'b0;
        bus.mag_index = '0;
        bus.mag_data  = '0;
        bus.mag_last  = 1'b0;
        bus.vsync     = 1'b0;
        bus.vaddr     = '0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [15:0] fdata(input int mode, input int idx);
        logic [15:0] v;
        v = 16'(idx);
        case (mode)
            0:       return v;
            1:       return 16'hFFFF;
            2:       return 16'hC000 | v;
            3:       return 16'hD000 | v;
            default: return 16'h7000 | v;
        endcase
    endfunction

    task automatic send_range(input int mode, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bus.mag_valid = 1'b1;
            bus.mag_index = 10'(i);
            bus.mag_data  = fdata(mode, i);
            bus.mag_last  = (i == 1023);
            tick();
        end
        bus.mag_valid = 1'b0;
        bus.mag_last  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (bus.vdata !== 16'h0) begin failures++; $display("FAIL reset_vdata got=%0h exp=0", bus.vdata); end
        checks++; if (bus.front_bank !== 1'b0) begin failures++; $display("FAIL reset_front got=%0b exp=0", bus.front_bank); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL reset_fvalid got=%0b exp=0", bus.frame_valid); end
        checks++; if (bus.swap !== 1'b0) begin failures++; $display("FAIL reset_swap got=%0b exp=0", bus.swap); end
        checks++; if (bus.frame_drops !== 8'd0) begin failures++; $display("FAIL reset_drops got=%0d exp=0", bus.frame_drops); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_swap();
        apply_reset();
        send_range(0, 0, 1023);
        checks++; if (bus.swap !== 1'b0) begin failures++; $display("FAIL basic_noswap_hold got=%0b exp=0", bus.swap); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL basic_fvalid_pre got=%0b exp=0", bus.frame_valid); end
        bus.vsync = 1'b1;
        bus.vaddr = 10'd9;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL basic_swap got=%0b exp=1", bus.swap); end
        checks++; if (bus.front_bank !== 1'b1) begin failures++; $display("FAIL basic_front got=%0b exp=1", bus.front_bank); end
        checks++; if (bus.frame_valid !== 1'b1) begin failures++; $display("FAIL basic_fvalid got=%0b exp=1", bus.frame_valid); end
        checks++; if (bus.vdata !== 16'd9) begin failures++; $display("FAIL basic_read_on_swap got=%0h exp=9", bus.vdata); end
        bus.vsync = 1'b0;
        bus.vaddr = 10'd5;
        tick();
        checks++; if (bus.swap !== 1'b0) begin failures++; $display("FAIL basic_swap_pulse got=%0b exp=0", bus.swap); end
        checks++; if (bus.vdata !== 16'd5) begin failures++; $display("FAIL basic_read5 got=%0h exp=5", bus.vdata); end
        bus.vaddr = 10'd1023;
        tick();
        checks++; if (bus.vdata !== 16'd1023) begin failures++; $display("FAIL basic_read1023 got=%0h exp=3ff", bus.vdata); end
    endtask

    task automatic test_drop();
        apply_reset();
        send_range(0, 0, 1023);
        send_range(1, 0, 1023);
        checks++; if (bus.frame_drops !== 8'd1) begin failures++; $display("FAIL drop_count got=%0d exp=1", bus.frame_drops); end
        bus.vsync = 1'b1;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL drop_swap got=%0b exp=1", bus.swap); end
        bus.vsync = 1'b0;
        bus.vaddr = 10'd7;
        tick();
        checks++; if (bus.vdata !== 16'd7) begin failures++; $display("FAIL drop_read7 got=%0h exp=7", bus.vdata); end
        send_range(3, 0, 1023);
        bus.vsync = 1'b1;
        tick();
        checks++; if (bus.front_bank !== 1'b0) begin failures++; $display("FAIL drop_next_front got=%0b exp=0", bus.front_bank); end
        bus.vsync = 1'b0;
        tick();
        checks++; if (bus.vdata !== 16'hD007) begin failures++; $display("FAIL drop_next_read got=%0h exp=d007", bus.vdata); end
    endtask

    task automatic test_skip();
        apply_reset();
        send_range(0, 0, 1023);
        send_range(2, 0, 299);
        bus.mag_valid = 1'b1;
        bus.mag_index = 10'd300;
        bus.mag_data  = fdata(2, 300);
        bus.mag_last  = 1'b0;
        bus.vsync     = 1'b1;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL skip_swap got=%0b exp=1", bus.swap); end
        checks++; if (bus.front_bank !== 1'b1) begin failures++; $display("FAIL skip_front got=%0b exp=1", bus.front_bank); end
        bus.vsync = 1'b0;
        send_range(2, 301, 1023);
        checks++; if (bus.frame_drops !== 8'd1) begin failures++; $display("FAIL skip_drops got=%0d exp=1", bus.frame_drops); end
        send_range(3, 0, 1023);
        checks++; if (bus.frame_drops !== 8'd1) begin failures++; $display("FAIL skip_d_drops got=%0d exp=1", bus.frame_drops); end
        bus.vsync = 1'b1;
        bus.vaddr = 10'd400;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL skip_d_swap got=%0b exp=1", bus.swap); end
        checks++; if (bus.vdata !== 16'hD190) begin failures++; $display("FAIL skip_d_read400 got=%0h exp=d190", bus.vdata); end
        bus.vsync = 1'b0;
        bus.vaddr = 10'd1000;
        tick();
        checks++; if (bus.vdata !== 16'hD3E8) begin failures++; $display("FAIL skip_d_read1000 got=%0h exp=d3e8", bus.vdata); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        send_range(0, 0, 1022);
        bus.mag_valid = 1'b1;
        bus.mag_index = 10'd1023;
        bus.mag_data  = 16'd1023;
        bus.mag_last  = 1'b1;
        bus.vsync     = 1'b1;
        tick();
        bus.mag_valid = 1'b0;
        bus.mag_last  = 1'b0;
        checks++; if (bus.swap !== 1'b0) begin failures++; $display("FAIL simul_noswap got=%0b exp=0", bus.swap); end
        tick();
        tick();
        checks++; if (bus.front_bank !== 1'b0) begin failures++; $display("FAIL simul_front got=%0b exp=0", bus.front_bank); end
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        bus.vaddr = 10'd1023;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL simul_later_swap got=%0b exp=1", bus.swap); end
        checks++; if (bus.vdata !== 16'd1023) begin failures++; $display("FAIL simul_last_written got=%0h exp=3ff", bus.vdata); end
        bus.vsync = 1'b0;
        tick();
    endtask

    task automatic test_vsync_hold();
        int pulses;
        apply_reset();
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            bus.vsync = 1'b1;
            tick();
            if (bus.swap === 1'b1) pulses++;
            bus.vsync = 1'b0;
            tick();
            if (bus.swap === 1'b1) pulses++;
        end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL vhold_fill_swaps got=%0d exp=0", pulses); end
        send_range(0, 0, 1023);
        pulses = 0;
        bus.vsync = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.swap === 1'b1) pulses++;
        end
        bus.vsync = 1'b0;
        tick();
        checks++; if (pulses !== 1) begin failures++; $display("FAIL vhold_swaps got=%0d exp=1", pulses); end
        checks++; if (bus.front_bank !== 1'b1) begin failures++; $display("FAIL vhold_front got=%0b exp=1", bus.front_bank); end
    endtask

    task automatic test_saturate_and_reset();
        apply_reset();
        send_range(0, 0, 1023);
        bus.mag_valid = 1'b1;
        bus.mag_last  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++; if (bus.frame_drops !== 8'd10) begin failures++; $display("FAIL sat_drops10 got=%0d exp=10", bus.frame_drops); end
        for (int i = 0; i < 290; i++) tick();
        bus.mag_valid = 1'b0;
        bus.mag_last  = 1'b0;
        checks++; if (bus.frame_drops !== 8'd255) begin failures++; $display("FAIL sat_drops255 got=%0d exp=255", bus.frame_drops); end
        bus.vsync = 1'b1;
        tick();
        checks++; if (bus.swap !== 1'b1) begin failures++; $display("FAIL sat_swap got=%0b exp=1", bus.swap); end
        bus.vsync = 1'b0;
        bus.vaddr = 10'd12;
        tick();
        checks++; if (bus.vdata !== 16'd12) begin failures++; $display("FAIL sat_read12 got=%0h exp=c", bus.vdata); end
        send_range(3, 0, 99);
        rst_n = 1'b0;
        #2;
        checks++; if (bus.vdata !== 16'h0) begin failures++; $display("FAIL arst_vdata got=%0h exp=0", bus.vdata); end
        checks++; if (bus.front_bank !== 1'b0) begin failures++; $display("FAIL arst_front got=%0b exp=0", bus.front_bank); end
        checks++; if (bus.frame_valid !== 1'b0) begin failures++; $display("FAIL arst_fvalid got=%0b exp=0", bus.frame_valid); end
        checks++; if (bus.frame_drops !== 8'd0) begin failures++; $display("FAIL arst_drops got=%0d exp=0", bus.frame_drops); end
        checks++; if (bus.swap !== 1'b0) begin failures++; $display("FAIL arst_swap got=%0b exp=0", bus.swap); end
        tick();
        rst_n = 1'b1;
        tick();
        send_range(4, 0, 1023);
        bus.vsync = 1'b1;
        bus.vaddr = 10'd50;
        tick();
        checks++; if (bus.front_bank !== 1'b1) begin failures++; $display("FAIL arst_next_front got=%0b exp=1", bus.front_bank); end
        checks++; if (bus.vdata !== 16'h7032) begin failures++; $display("FAIL arst_next_read got=%0h exp=7032", bus.vdata); end
        bus.vsync = 1'b0;
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_basic_swap();
        test_drop();
        test_skip();
        test_simultaneous();
        test_vsync_hold();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
